// File: rtl/axis_fifo_wr_control.sv
// axis_fifo_wr_control
//   Write-side controller for the TX staging FIFO. Accepts AXI-Stream beats,
//   generates the FIFO write strobe, tracks occupancy and per-frame word count,
//   signals the reader once enough of a frame is buffered, and after each TLAST
//   holds off new frames until the FIFO has drained (or a flush timeout hits).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   axis_in_TVALID/TLAST      upstream beat valid / last beat of frame
//   axis_in_TREADY            beat accepted when TVALID & TREADY
//   GT_Tx_active              transceiver TX ready; writes blocked while low
//   fifo_full                 FIFO full flag
//   fifo_rd_enable            read strobe from the read controller
//   fifo_wr_enable            FIFO write strobe
//   fifo_min_data_write_done  frame sufficiently buffered; reader may start
//   fifo_level                current occupancy
//   frame_count               completed frames written (wraps at 16 bits)
//   err_underflow             sticky: read seen at level 0
//   err_flush_timeout         sticky: flush ended by timeout
module axis_fifo_wr_control #(
  parameter int MIN_WORDS     = 16,
  parameter int LEVEL_W       = 8,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axis_in_TVALID,
  input  logic               axis_in_TLAST,
  output logic               axis_in_TREADY,
  input  logic               GT_Tx_active,
  input  logic               fifo_full,
  input  logic               fifo_rd_enable,
  output logic               fifo_wr_enable,
  output logic               fifo_min_data_write_done,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [15:0]        frame_count,
  output logic               err_underflow,
  output logic               err_flush_timeout
);

  localparam int CNT_W = $clog2(MIN_WORDS + 1);
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WORDS_MAX = CNT_W'(MIN_WORDS);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FILL, ARMED, FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [TMR_W-1:0] flush_tmr;

  function automatic logic [LEVEL_W-1:0] level_sat_inc(input logic [LEVEL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] words_sat_inc(input logic [CNT_W-1:0] v);
    return (v >= WORDS_MAX) ? WORDS_MAX : v + 1'b1;
  endfunction

  // Zero-latency handshake: TREADY is forced low during reset and while flushing.
  always_comb begin
    axis_in_TREADY = GT_Tx_active & ~fifo_full & (state != FLUSH) & ~rst;
    fifo_wr_enable = axis_in_TVALID & axis_in_TREADY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      fifo_level               <= '0;
      word_cnt                 <= '0;
      flush_tmr                <= '0;
      frame_count              <= '0;
      fifo_min_data_write_done <= 1'b0;
      err_underflow            <= 1'b0;
      err_flush_timeout        <= 1'b0;
    end else begin
      // A simultaneous write and read cancel; a lone read at zero only flags.
      if (fifo_wr_enable && !fifo_rd_enable)
        fifo_level <= level_sat_inc(fifo_level);
      else if (!fifo_wr_enable && fifo_rd_enable && fifo_level != '0)
        fifo_level <= fifo_level - 1'b1;

      if (fifo_rd_enable && fifo_level == '0)
        err_underflow <= 1'b1;

      if (fifo_wr_enable) begin
        word_cnt <= words_sat_inc(word_cnt);
        if (axis_in_TLAST)
          frame_count <= frame_count + 16'd1;
        // Raised on the edge where the count reaches MIN_WORDS or TLAST lands.
        if (axis_in_TLAST || word_cnt >= WORDS_MAX - 1'b1)
          fifo_min_data_write_done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fifo_wr_enable)
            state <= axis_in_TLAST ? FLUSH : FILL;
        end
        FILL: begin
          if (fifo_wr_enable && axis_in_TLAST)
            state <= FLUSH;
          else if (word_cnt == WORDS_MAX)
            state <= ARMED;
        end
        ARMED: begin
          if (fifo_wr_enable && axis_in_TLAST)
            state <= FLUSH;
        end
        FLUSH: begin
          if (fifo_level == '0 && !fifo_rd_enable) begin
            state                    <= IDLE;
            word_cnt                 <= '0;
            flush_tmr                <= '0;
            fifo_min_data_write_done <= 1'b0;
          end else if (flush_tmr == TMR_LAST) begin
            // Reader stalled: give up after FLUSH_TIMEOUT cycles, keep the level.
            state                    <= IDLE;
            word_cnt                 <= '0;
            flush_tmr                <= '0;
            fifo_min_data_write_done <= 1'b0;
            err_flush_timeout        <= 1'b1;
          end else begin
            flush_tmr <= flush_tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_wr_control.sv
// Directed bench for axis_fifo_wr_control. Stimulus drives one cycle at a time
// and pushes the values it expects to observe in that cycle onto a queue; an
// independent monitor pops and compares them on the falling edge.
module tb_axis_fifo_wr_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0, tlast = 1'b0, gt = 1'b0, full = 1'b0, rd = 1'b0;
  logic        tready, wr, min_done, uf, to;
  logic [7:0]  level;
  logic [15:0] fc;

  axis_fifo_wr_control #(.MIN_WORDS(16), .LEVEL_W(8), .FLUSH_TIMEOUT(255)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .axis_in_TVALID           (tvalid),
    .axis_in_TLAST            (tlast),
    .axis_in_TREADY           (tready),
    .GT_Tx_active             (gt),
    .fifo_full                (full),
    .fifo_rd_enable           (rd),
    .fifo_wr_enable           (wr),
    .fifo_min_data_write_done (min_done),
    .fifo_level               (level),
    .frame_count              (fc),
    .err_underflow            (uf),
    .err_flush_timeout        (to)
  );

  always #5 clk = ~clk;

  localparam int S_TREADY = 0, S_WR = 1, S_LEVEL = 2, S_MIN = 3, S_FC = 4, S_UF = 5, S_TO = 6;

  typedef struct {
    int    cyc;
    string nm;
    int    sel;
    int    exp;
  } chk_t;

  chk_t sq[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int obs(input int sel);
    case (sel)
      S_TREADY: return int'(tready);
      S_WR:     return int'(wr);
      S_LEVEL:  return int'(level);
      S_MIN:    return int'(min_done);
      S_FC:     return int'(fc);
      S_UF:     return int'(uf);
      default:  return int'(to);
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    chk_t c;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      c = sq.pop_front();
      n_run++;
      if (obs(c.sel) != c.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", c.nm, c.cyc, obs(c.sel), c.exp);
      end
    end
  end

  task automatic expect_now(input string nm, input int sel, input int exp);
    sq.push_back('{cyc, nm, sel, exp});
  endtask

  task automatic drive(input logic v, input logic l, input logic r,
                       input logic g, input logic f, input logic rs);
    @(posedge clk);
    #1;
    tvalid = v; tlast = l; rd = r; gt = g; full = f; rst = rs;
  endtask

  task automatic step(input logic v, input logic l, input logic r);
    drive(v, l, r, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: TREADY held low by rst even with TVALID and GT active.
    drive(1, 0, 0, 1, 0, 1);
    expect_now("rst_tready", S_TREADY, 0);
    expect_now("rst_wr", S_WR, 0);
    expect_now("rst_level", S_LEVEL, 0);
    expect_now("rst_min", S_MIN, 0);
    expect_now("rst_fc", S_FC, 0);
    expect_now("rst_uf", S_UF, 0);
    expect_now("rst_to", S_TO, 0);
    drive(0, 0, 0, 1, 0, 1);
    step(0, 0, 0);
    expect_now("idle_tready", S_TREADY, 1);

    // 32-beat frame, no reads; min_done the cycle after beat 16.
    for (int i = 0; i < 32; i++) begin
      step(1, i == 31, 0);
      expect_now("f32_wr", S_WR, 1);
      expect_now("f32_level", S_LEVEL, i);
      expect_now("f32_min", S_MIN, (i >= 16) ? 1 : 0);
    end
    for (int j = 0; j < 32; j++) begin
      step(j == 0, 0, 1);
      expect_now("f32_flush_tready", S_TREADY, 0);
      expect_now("f32_drain_level", S_LEVEL, 32 - j);
      if (j == 0) begin
        expect_now("f32_flush_wr", S_WR, 0);
        expect_now("f32_fc", S_FC, 1);
        expect_now("f32_flush_min", S_MIN, 1);
      end
    end
    step(0, 0, 0);
    expect_now("f32_empty_level", S_LEVEL, 0);
    expect_now("f32_empty_tready", S_TREADY, 0);
    step(0, 0, 0);
    expect_now("f32_idle_tready", S_TREADY, 1);
    expect_now("f32_idle_min", S_MIN, 0);
    expect_now("f32_idle_to", S_TO, 0);

    // 5-beat short frame, then drained by 5 reads.
    for (int i = 0; i < 5; i++) begin
      step(1, i == 4, 0);
      expect_now("short_wr", S_WR, 1);
      expect_now("short_level", S_LEVEL, i);
      expect_now("short_min", S_MIN, 0);
    end
    for (int j = 0; j < 5; j++) begin
      step(0, 0, 1);
      expect_now("short_drain_level", S_LEVEL, 5 - j);
      expect_now("short_flush_tready", S_TREADY, 0);
      expect_now("short_flush_min", S_MIN, 1);
      if (j == 0) expect_now("short_fc", S_FC, 2);
    end
    step(0, 0, 0);
    expect_now("short_empty_level", S_LEVEL, 0);
    expect_now("short_empty_tready", S_TREADY, 0);
    step(0, 0, 0);
    expect_now("short_idle_tready", S_TREADY, 1);
    expect_now("short_idle_min", S_MIN, 0);

    // Level 7, then 10 cycles of simultaneous write+read.
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      expect_now("wr7_level", S_LEVEL, i);
    end
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 1);
      expect_now("wrrd_wr", S_WR, 1);
      expect_now("wrrd_level", S_LEVEL, 7);
      expect_now("wrrd_min", S_MIN, (k >= 9) ? 1 : 0);
    end
    for (int j = 0; j < 7; j++) begin
      step(0, 0, 1);
      expect_now("rd7_level", S_LEVEL, 7 - j);
    end
    step(0, 0, 1);
    expect_now("uf_pre_level", S_LEVEL, 0);
    expect_now("uf_pre", S_UF, 0);
    step(0, 0, 0);
    expect_now("uf_level", S_LEVEL, 0);
    expect_now("uf_flag", S_UF, 1);
    step(1, 1, 0);
    expect_now("armed_last_wr", S_WR, 1);
    expect_now("armed_last_level", S_LEVEL, 0);
    expect_now("armed_last_fc", S_FC, 2);
    step(0, 0, 1);
    expect_now("armed_flush_tready", S_TREADY, 0);
    expect_now("armed_flush_level", S_LEVEL, 1);
    expect_now("armed_flush_fc", S_FC, 3);
    step(0, 0, 0);
    expect_now("armed_empty_tready", S_TREADY, 0);
    step(0, 0, 0);
    expect_now("armed_idle_tready", S_TREADY, 1);
    expect_now("armed_idle_min", S_MIN, 0);

    // fifo_full and GT_Tx_active stalls mid-frame; word count must not move.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      expect_now("stall_pre_level", S_LEVEL, i);
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1, 0, 0, 1, 1, 0);
      else       drive(1, 0, 0, 0, 0, 0);
      expect_now("stall_tready", S_TREADY, 0);
      expect_now("stall_wr", S_WR, 0);
      expect_now("stall_level", S_LEVEL, 10);
      expect_now("stall_min", S_MIN, 0);
    end
    for (int i = 10; i < 18; i++) begin
      step(1, i == 17, 0);
      expect_now("stall_post_wr", S_WR, 1);
      expect_now("stall_post_level", S_LEVEL, i);
      expect_now("stall_post_min", S_MIN, (i >= 16) ? 1 : 0);
    end

    // Flush with no reads: 255 cycles with TREADY low, then timeout exit.
    for (int t = 0; t < 256; t++) begin
      step(0, 0, 0);
      expect_now("tmo_level", S_LEVEL, 18);
      if (t < 255) begin
        expect_now("tmo_tready", S_TREADY, 0);
        if (t == 0)   expect_now("tmo_fc", S_FC, 4);
        if (t == 254) expect_now("tmo_to_early", S_TO, 0);
      end else begin
        expect_now("tmo_exit_tready", S_TREADY, 1);
        expect_now("tmo_flag", S_TO, 1);
        expect_now("tmo_exit_min", S_MIN, 0);
      end
    end

    // Reset mid-FILL after 9 beats.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0);
      expect_now("mid_wr", S_WR, 1);
      expect_now("mid_level", S_LEVEL, 18 + i);
    end
    drive(1, 0, 0, 1, 0, 1);
    expect_now("mid_rst_tready", S_TREADY, 0);
    expect_now("mid_rst_wr", S_WR, 0);
    step(0, 0, 0);
    expect_now("post_rst_level", S_LEVEL, 0);
    expect_now("post_rst_fc", S_FC, 0);
    expect_now("post_rst_min", S_MIN, 0);
    expect_now("post_rst_uf", S_UF, 0);
    expect_now("post_rst_to", S_TO, 0);
    expect_now("post_rst_tready", S_TREADY, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, i == 19, 0);
      expect_now("f20_level", S_LEVEL, i);
      expect_now("f20_min", S_MIN, (i >= 16) ? 1 : 0);
    end
    step(0, 0, 0);
    expect_now("f20_fc", S_FC, 1);
    expect_now("f20_tready", S_TREADY, 0);
    expect_now("f20_level_end", S_LEVEL, 20);
    expect_now("f20_min_end", S_MIN, 1);

    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    if (sq.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_fifo_wr_control.md
Name: axis_fifo_wr_control

Overview:
- Write-side controller for the TX staging FIFO. It is the producer-end counterpart of the FIFO read controller.
- Accepts AXI-Stream beats from the upstream datapath and generates the FIFO write enable.
- Tracks FIFO occupancy and the per-frame word count. Raises fifo_min_data_write_done once enough of a frame is buffered for the reader to start.
- After each TLAST it blocks new frames until the reader has drained the FIFO.

Parameters:
- MIN_WORDS, 16: words of a frame that must be written before fifo_min_data_write_done asserts.
- LEVEL_W, 8: width of the occupancy counter; FIFO depth is at most 2^LEVEL_W-1.
- FLUSH_TIMEOUT, 255: maximum cycles spent in FLUSH before forced exit.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- axis_in_TVALID  in  1  upstream beat valid.
- axis_in_TLAST  in  1  upstream last beat of frame.
- axis_in_TREADY  out  1  beat accepted when TVALID and TREADY are both high.
- GT_Tx_active  in  1  transceiver TX ready; writes are blocked while low.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_enable  in  1  read strobe from the read controller; one word per cycle.
- fifo_wr_enable  out  1  FIFO write strobe.
- fifo_min_data_write_done  out  1  frame sufficiently buffered; reader may start.
- fifo_level  out  LEVEL_W  current occupancy.
- frame_count  out  16  completed frames written, wraps at 16 bits.
- err_underflow  out  1  sticky: read seen while fifo_level==0.
- err_flush_timeout  out  1  sticky: FLUSH exited by timeout.

Behaviour:
- Reset (synchronous, rst high at clk edge) sets the following:
  - state=IDLE.
  - fifo_level, word counter, flush timer and frame_count = 0.
  - fifo_min_data_write_done, err_underflow and err_flush_timeout = 0.
- rst overrides everything, including mid-frame and mid-FLUSH. Any partial frame count is discarded.
- axis_in_TREADY = GT_Tx_active & ~fifo_full & (state != FLUSH) & ~rst. This is combinational from inputs and registered state.
- fifo_wr_enable = axis_in_TVALID & axis_in_TREADY. It is combinational, so a write is accepted in the same cycle (zero latency).
- fifo_level update:
  - +1 on a write only.
  - -1 on fifo_rd_enable only, when level > 0.
  - Unchanged when a write and a read occur in the same cycle.
  - A read at level 0 leaves the level at 0 and sets err_underflow.
  - Increment saturates at 2^LEVEL_W-1 (fifo_full must prevent reaching it).
- Word counter: +1 per accepted beat, saturating at MIN_WORDS.
- States:
  - IDLE: the first accepted beat goes to FILL. If that beat also has TLAST, it goes directly to FLUSH.
  - FILL: beats are accepted. When the registered word counter reaches MIN_WORDS, go to ARMED. An accepted TLAST goes to FLUSH (short frame).
  - ARMED: beats continue to be accepted. An accepted TLAST goes to FLUSH.
  - FLUSH: TREADY is held low and the flush timer counts up.
    - Exit to IDLE when fifo_level==0 and fifo_rd_enable is low.
    - Otherwise exit to IDLE when the timer reaches FLUSH_TIMEOUT, and set err_flush_timeout.
    - On exit, clear the word counter and the timer.
- fifo_min_data_write_done (registered):
  - Asserts one cycle after the word counter reaches MIN_WORDS, or one cycle after TLAST is accepted, whichever comes first.
  - Held high through ARMED and FLUSH.
  - Cleared on the cycle the FSM returns to IDLE.
- frame_count: increments on each accepted TLAST beat; 0xFFFF wraps to 0x0000.
- GT_Tx_active low mid-frame stalls acceptance only. State, counters and min_done are held.
- fifo_full stalls the same way. No beat is lost or double-counted.
- TLAST on the beat that makes the word counter reach MIN_WORDS: the FSM goes to FLUSH, and min_done asserts once.

Test Plan:
- 32-beat frame, TVALID continuous, GT_Tx_active=1, MIN_WORDS=16, no reads:
  - min_done rises the cycle after the 16th accepted beat.
  - After TLAST, TREADY=0 and fifo_level=32.
  - frame_count=1.
- 5-beat short frame (TLAST on beat 5):
  - min_done rises the cycle after beat 5.
  - FSM is in FLUSH.
  - Issue 5 reads: level goes to 0, FSM returns to IDLE next cycle, min_done=0.
- Simultaneous write and read for 10 cycles at level 7 -> level stays 7. Then one read at level 0 -> err_underflow=1, level=0.
- fifo_full held high for 4 cycles mid-frame -> TREADY=0, fifo_wr_enable=0, word counter frozen. Resumes with no missing or duplicate count.
- FLUSH with no reads, FLUSH_TIMEOUT=255 -> exit to IDLE after 255 cycles, err_flush_timeout=1, fifo_level retained.
- rst pulsed mid-FILL after 9 beats -> next cycle all counters and flags are 0 and state is IDLE. Then a 20-beat frame gives min_done after beat 16.
